// File: rtl/mac_frame_packer.sv
// Packs a 48-bit MAC into a 32-bit word stream with 0-3 leading pad bytes,
// preceded by a comparator clear pulse and followed by TAIL_WORDS zero words.
module mac_frame_packer #(
    parameter int TAIL_WORDS = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [47:0] mac_in,
    input  logic [1:0]  offset_in,
    input  logic        ready_in,
    output logic        busy,
    output logic        clear_out,
    output logic [31:0] data_out,
    output logic        valid_out,
    output logic [3:0]  byte_en,
    output logic        last_out,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, CLR, SEND, TAIL} state_t;

    localparam logic [3:0] TAIL_LAST = (TAIL_WORDS > 0) ? 4'(TAIL_WORDS - 1) : 4'd0;

    state_t      state_q, state_d;
    logic [47:0] mac_q, mac_d;
    logic [1:0]  off_q, off_d;
    logic [3:0]  idx_q, idx_d;
    logic        done_q, done_d;

    logic [3:0]   hdr_last;
    logic         accept;
    logic [127:0] stream;
    logic [15:0]  lane_mask;

    // Pad bytes occupy the low lanes, so shifting the MAC up by the offset
    // lays out the whole header in time order.
    assign hdr_last  = (off_q == 2'd3) ? 4'd2 : 4'd1;
    assign accept    = valid_out && ready_in;
    assign stream    = {80'd0, mac_q} << {off_q, 3'b000};
    assign lane_mask = {10'd0, 6'h3f} << off_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 4'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        mac_q <= mac_d;
        off_q <= off_d;
    end

    always_comb begin
        state_d = state_q;
        mac_d   = mac_q;
        off_d   = off_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mac_d   = mac_in;
                    off_d   = offset_in;
                    idx_d   = 4'd0;
                    state_d = CLR;
                end
            end
            CLR: state_d = SEND;
            SEND: begin
                if (accept) begin
                    if (idx_q == hdr_last) begin
                        idx_d = 4'd0;
                        if (TAIL_WORDS > 0) begin
                            state_d = TAIL;
                        end else begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            TAIL: begin
                if (accept) begin
                    if (idx_q == TAIL_LAST) begin
                        idx_d   = 4'd0;
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs depend only on registered state, so they hold during a stall.
    always_comb begin
        busy      = (state_q != IDLE);
        clear_out = (state_q == CLR);
        valid_out = 1'b0;
        data_out  = 32'd0;
        byte_en   = 4'd0;
        last_out  = 1'b0;
        done      = done_q;
        case (state_q)
            SEND: begin
                valid_out = 1'b1;
                data_out  = stream[{idx_q[1:0], 5'd0} +: 32];
                byte_en   = lane_mask[{idx_q[1:0], 2'd0} +: 4];
                last_out  = (TAIL_WORDS == 0) && (idx_q == hdr_last);
            end
            TAIL: begin
                valid_out = 1'b1;
                last_out  = (idx_q == TAIL_LAST);
            end
            default: ;
        endcase
    end

endmodule
